// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: per-source edge/level capture, enable mask,
// lowest-index arbitration and a req/ack/iret handshake with the control decoder.
module irq_ctrl #(
   parameter int          N_SRC     = 4,
   parameter logic [31:0] EDGE_MASK = 32'hFFFF_FFFF,
   parameter int          CAUSE_W   = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [N_SRC-1:0]   irq_src,
   input  logic               kernel_mode,
   output logic               irq_req,
   input  logic               irq_ack,
   input  logic               iret,
   output logic [CAUSE_W-1:0] cause_id,
   output logic               in_service,
   input  logic               cfg_wr,
   input  logic [1:0]         cfg_addr,
   input  logic [31:0]        cfg_wdata,
   output logic [31:0]        cfg_rdata
);

   localparam logic [N_SRC-1:0] EDGE_SRC = EDGE_MASK[N_SRC-1:0];

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [N_SRC-1:0]   enable_q, enable_d;
   logic [N_SRC-1:0]   pending_q, pending_d;
   logic [N_SRC-1:0]   prev_q, prev_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;

   logic [N_SRC-1:0]   active;
   logic [N_SRC-1:0]   w1c;
   logic [N_SRC-1:0]   ack_clr;
   logic [CAUSE_W-1:0] lowest_idx;
   logic               take_ack;
   logic               wr_enable;
   logic               wr_pending;
   logic               unused_wdata;

   assign wr_enable    = cfg_wr && (cfg_addr == 2'd0);
   assign wr_pending   = cfg_wr && (cfg_addr == 2'd1);
   assign active       = pending_q & enable_q;
   assign unused_wdata = ^cfg_wdata;

   always_comb begin
      enable_d = enable_q;
      if (wr_enable) begin
         enable_d = cfg_wdata[N_SRC-1:0];
      end
      prev_d = irq_src;
      w1c    = wr_pending ? cfg_wdata[N_SRC-1:0] : '0;
   end

   // Edge sources: a fresh edge beats a simultaneous W1C or ack clear.
   // Level sources simply track the line; W1C and ack cannot touch them.
   genvar gi;
   generate
      for (gi = 0; gi < N_SRC; gi++) begin : g_src
         assign ack_clr[gi]   = take_ack && (cause_q == CAUSE_W'(gi));
         assign pending_d[gi] = EDGE_SRC[gi]
            ? ((irq_src[gi] & ~prev_q[gi]) | (pending_q[gi] & ~(w1c[gi] | ack_clr[gi])))
            : irq_src[gi];
      end
   endgenerate

   always_comb begin
      lowest_idx = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            lowest_idx = CAUSE_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cause_d    = cause_q;
      irq_req    = 1'b0;
      in_service = 1'b0;
      take_ack   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if ((|active) && !kernel_mode) begin
               cause_d = lowest_idx;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // Kernel mode only masks the request line; the latched cause is kept.
            irq_req = !kernel_mode;
            if (irq_ack && !kernel_mode) begin
               take_ack = 1'b1;
               state_d  = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            in_service = 1'b1;
            if (iret) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         2'd0:    cfg_rdata[N_SRC-1:0]   = enable_q;
         2'd1:    cfg_rdata[N_SRC-1:0]   = pending_q;
         2'd2:    cfg_rdata[CAUSE_W-1:0] = cause_q;
         default: cfg_rdata[1:0]         = state_q;
      endcase
   end

   assign cause_id = cause_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         enable_q  <= '0;
         pending_q <= '0;
         prev_q    <= '0;
         cause_q   <= '0;
      end else begin
         state_q   <= state_d;
         enable_q  <= enable_d;
         pending_q <= pending_d;
         prev_q    <= prev_d;
         cause_q   <= cause_d;
      end
   end

endmodule
